// File: rtl/panel_ctrl_if.sv
// Front-panel signal bundle: raw buttons and done in, programme controls and lights out.
interface panel_ctrl_if;
   logic       bt_mode;
   logic       bt_start;
   logic       bt_pause;
   logic       done;
   logic [1:0] mode;
   logic       start;
   logic       abort;
   logic       pause;
   logic [3:0] mode_light;
   logic       run_light;

   modport master (
      input  bt_mode, bt_start, bt_pause, done,
      output mode, start, abort, pause, mode_light, run_light
   );

   modport slave (
      output bt_mode, bt_start, bt_pause, done,
      input  mode, start, abort, pause, mode_light, run_light
   );
endinterface

// File: rtl/panel_ctrl.sv
// Washer front-panel controller: synchronises and debounces three buttons,
// turns them into press/long-press events and sequences SETUP/RUN/PAUSE.
module panel_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 2000000,
   parameter int unsigned LONG_CYCLES     = 200000000
) (
   input logic          clk,
   input logic          rst,
   panel_ctrl_if.master pif
);

   localparam int unsigned NBTN      = 3;
   localparam int unsigned DBW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned LGW       = $clog2(LONG_CYCLES + 1);
   localparam int unsigned BTN_MODE  = 0;
   localparam int unsigned BTN_START = 1;
   localparam int unsigned BTN_PAUSE = 2;

   typedef enum logic [1:0] {
      SETUP = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   logic [NBTN-1:0] raw_c;
   logic [NBTN-1:0] sync1_q;
   logic [NBTN-1:0] sync2_q;
   logic [NBTN-1:0] deb_c;
   logic [NBTN-1:0] deb_d1_q;
   logic [NBTN-1:0] press_c;
   logic [LGW-1:0]  long_cnt_q;
   logic            long_c;

   state_t          state_q;
   logic [1:0]      mode_q;
   logic [3:0]      mode_light_q;
   logic            start_q;
   logic            abort_q;
   logic            pause_q;
   logic            run_light_q;
   logic            hold_used_q;

   assign raw_c = {pif.bt_pause, pif.bt_start, pif.bt_mode};

   // Two-flop synchronisers for the asynchronous button inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_c;
         sync2_q <= sync1_q;
      end
   end

   // Per-button debouncer: flip only after a full run of disagreeing samples
   for (genvar b = 0; b < NBTN; b++) begin : g_deb
      logic [DBW-1:0] cnt_q;
      logic           lvl_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else if (sync2_q[b] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q <= '0;
            lvl_q <= sync2_q[b];
         end else begin
            cnt_q <= cnt_q + DBW'(1);
         end
      end

      assign deb_c[b] = lvl_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_d1_q <= '0;
      end else begin
         deb_d1_q <= deb_c;
      end
   end

   assign press_c = deb_c & ~deb_d1_q;

   // Hold timer on debounced start; saturates so the long event fires once per hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         long_cnt_q <= '0;
      end else if (!deb_c[BTN_START]) begin
         long_cnt_q <= '0;
      end else if (long_cnt_q != LGW'(LONG_CYCLES)) begin
         long_cnt_q <= long_cnt_q + LGW'(1);
      end
   end

   assign long_c = deb_c[BTN_START] && (long_cnt_q == LGW'(LONG_CYCLES - 1));

   // Programme sequencer; hold_used_q stops the hold that launched a run from aborting it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SETUP;
         mode_q       <= 2'b01;
         mode_light_q <= 4'b0010;
         start_q      <= 1'b0;
         abort_q      <= 1'b0;
         pause_q      <= 1'b0;
         run_light_q  <= 1'b0;
         hold_used_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         abort_q <= 1'b0;
         if (!deb_c[BTN_START]) begin
            hold_used_q <= 1'b0;
         end
         unique case (state_q)
            SETUP: begin
               if (press_c[BTN_START]) begin
                  start_q     <= 1'b1;
                  run_light_q <= 1'b1;
                  hold_used_q <= 1'b1;
                  state_q     <= RUN;
               end else if (press_c[BTN_MODE]) begin
                  mode_q       <= mode_q + 2'd1;
                  mode_light_q <= {mode_light_q[2:0], mode_light_q[3]};
               end
            end
            RUN, PAUSE: begin
               if (pif.done) begin
                  pause_q     <= 1'b0;
                  run_light_q <= 1'b0;
                  state_q     <= SETUP;
               end else if (long_c && !hold_used_q) begin
                  abort_q     <= 1'b1;
                  pause_q     <= 1'b0;
                  run_light_q <= 1'b0;
                  state_q     <= SETUP;
               end else if (press_c[BTN_PAUSE]) begin
                  pause_q <= (state_q == RUN);
                  state_q <= (state_q == RUN) ? PAUSE : RUN;
               end
            end
            default: begin
               pause_q     <= 1'b0;
               run_light_q <= 1'b0;
               state_q     <= SETUP;
            end
         endcase
      end
   end

   assign pif.mode       = mode_q;
   assign pif.mode_light = mode_light_q;
   assign pif.start      = start_q;
   assign pif.abort      = abort_q;
   assign pif.pause      = pause_q;
   assign pif.run_light  = run_light_q;

endmodule

// File: doc/panel_ctrl.md
PANEL_CTRL -- requirements
Module: panel_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2000000, consecutive stable cycles before a raw button level is accepted (20 ms at 100 MHz).
REQ-002 Parameter LONG_CYCLES, default 200000000, debounced hold time on bt_start that counts as a long press (2 s at 100 MHz).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 bt_mode  input  1  raw mode-select button, active-high, asynchronous to clk.
REQ-006 bt_start  input  1  raw start/abort button, active-high, asynchronous to clk.
REQ-007 bt_pause  input  1  raw pause/resume button, active-high, asynchronous to clk.
REQ-008 done  input  1  washer cycle-complete level/pulse from the wash controller.
REQ-009 mode  output  2  selected programme: 00 spin-only, 01 small, 10 medium, 11 large.
REQ-010 start  output  1  one-cycle pulse that launches the wash controller.
REQ-011 abort  output  1  one-cycle pulse that cancels a running programme.
REQ-012 pause  output  1  level, high while the programme is paused.
REQ-013 mode_light  output  4  one-hot mode indicator, bit[mode] set.
REQ-014 run_light  output  1  high in RUN or PAUSE.

Function
REQ-015 Each raw button SHALL pass a 2-flop synchroniser before any other logic.
REQ-016 Each button SHALL have its own debounce counter; the debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-017 A press event SHALL be a one-cycle pulse in the cycle after the debounced level goes 0->1; release generates no event.
REQ-018 Long-press: a counter SHALL run while debounced bt_start is high and clear when low; long event is a one-cycle pulse when the counter reaches LONG_CYCLES, at most once per hold.
REQ-019 FSM states SETUP, RUN, PAUSE; reset state SETUP.
REQ-020 SETUP: mode event increments mode modulo 4 (11 wraps to 00); start event asserts start for one cycle in the same cycle the FSM moves to RUN.
REQ-021 SETUP: mode and start events in the same cycle -> start wins, mode unchanged, start issued with current mode.
REQ-022 mode SHALL be frozen in RUN and PAUSE; mode events there are ignored.
REQ-023 RUN: pause event -> PAUSE, pause=1; start short-press events ignored.
REQ-024 PAUSE: pause event -> RUN, pause=0.
REQ-025 RUN or PAUSE: long event -> abort pulse one cycle, pause=0, go SETUP, mode retained.
REQ-026 RUN or PAUSE: done high -> SETUP, pause=0, no abort pulse; done ignored in SETUP.
REQ-027 Priority on the same cycle in RUN/PAUSE: done > long > pause event.
REQ-028 A start press that later becomes a long hold in SETUP SHALL produce only the start pulse; the long event during that same hold is ignored.
REQ-029 start and abort SHALL never be high in the same cycle.
REQ-030 All outputs SHALL be registered.
REQ-031 Counters SHALL saturate/clear and never wrap.

Reset
REQ-032 While rst=0: state SETUP, mode=01, mode_light=0010, start=0, abort=0, pause=0, run_light=0, all debounce/long counters and debounced levels 0, synchronisers 0.
REQ-033 Reset asserted mid-RUN SHALL return to these values immediately without emitting abort.
REQ-034 After rst release the first press event SHALL need a full DEBOUNCE_CYCLES of stable input.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-035 Bounce: bt_mode toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one mode step 01->10, mode_light=0100.
REQ-036 Wrap: four clean mode presses from reset -> mode 10,11,00,01; mode_light 0100,1000,0001,0010.
REQ-037 Start: press bt_start in SETUP with mode=11 -> single start pulse, run_light=1, later mode presses leave mode=11.
REQ-038 Pause: in RUN press bt_pause twice -> pause 1 then 0; done pulse then -> SETUP, run_light=0, no abort.
REQ-039 Abort: in PAUSE hold bt_start 30 cycles -> one abort pulse about 20 cycles after debounced rise, pause=0, SETUP, mode unchanged.
REQ-040 Collisions: done and long in same cycle -> SETUP, no abort; rst low mid-RUN -> all outputs to reset values, mode=01.
